// File: rtl/seq_step_sequencer_if.sv
// Controller-side bundle for seq_step_sequencer: operation request, step
// strobes and the sequencer's status back to the multiplier controller.
// The err status line exists only when SEQ_STEP_SEQUENCER_ERR_EN is defined.
interface seq_step_sequencer_if #(
   parameter int CNT_W = 4
);
   logic             start;
   logic [CNT_W:0]   len;
   logic             add_shift;
   logic             shift;
   logic [CNT_W-1:0] count;
   logic             count_check;
   logic             busy;
   logic             done;
`ifdef SEQ_STEP_SEQUENCER_ERR_EN
   logic             err;

   // Controller drives requests and strobes, observes status.
   modport master (
      output start, len, add_shift, shift,
      input  count, count_check, busy, done, err
   );

   // Sequencer receives requests and strobes, drives status.
   modport slave (
      input  start, len, add_shift, shift,
      output count, count_check, busy, done, err
   );
`else
   // Controller drives requests and strobes, observes status.
   modport master (
      output start, len, add_shift, shift,
      input  count, count_check, busy, done
   );

   // Sequencer receives requests and strobes, drives status.
   modport slave (
      input  start, len, add_shift, shift,
      output count, count_check, busy, done
   );
`endif
endinterface

// File: rtl/seq_step_sequencer.sv
// Step sequencer for the sequential multiplier datapath.
// Counts add-shift / shift steps for an operation length latched at start,
// reporting busy, a last-step flag and a one-cycle done pulse.
// Optional feature: define SEQ_STEP_SEQUENCER_ERR_EN to add a sticky err
// status flagging strobes outside RUN and start requests during RUN.
module seq_step_sequencer #(
   parameter int CNT_W     = 4,
   parameter int MAX_STEPS = 16
) (
   input logic                clk,
   input logic                reset,
   seq_step_sequencer_if.slave bus
);

   localparam logic [CNT_W:0] MAX_LEN = (CNT_W + 1)'(MAX_STEPS);
   localparam logic [CNT_W:0] LEN_ONE = (CNT_W + 1)'(1);

   // Reject step limits the count register cannot represent.
   if (MAX_STEPS < 1 || MAX_STEPS > (1 << CNT_W)) begin : g_bad_max_steps
      $error("seq_step_sequencer: MAX_STEPS must be in 1..2**CNT_W");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W:0]   len_q;
   logic             busy_q;
   logic             done_q;

   logic             step;
   logic             accept;
   logic             last_step;
   logic [CNT_W:0]   len_clamped;

   assign step        = bus.add_shift | bus.shift;
   assign accept      = bus.start && (state_q == S_IDLE || state_q == S_DONE);
   assign last_step   = ({1'b0, count_q} == (len_q - LEN_ONE));
   assign len_clamped = (bus.len == '0 || bus.len > MAX_LEN) ? MAX_LEN : bus.len;

   // Main FSM: state, step counter, latched length and registered status.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         count_q <= '0;
         len_q   <= MAX_LEN;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (accept) begin
                  len_q   <= len_clamped;
                  count_q <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            S_RUN: begin
               if (step) begin
                  if (last_step) begin
                     count_q <= '0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     count_q <= count_q + 1'b1;
                  end
               end
            end
            default: begin
               count_q <= '0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.count       = count_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.count_check = (state_q == S_RUN) && last_step;

`ifdef SEQ_STEP_SEQUENCER_ERR_EN
   logic err_q;
   logic err_set;

   assign err_set = (step && state_q != S_RUN) || (bus.start && state_q == S_RUN);

   // Sticky protocol-error flag; an accepted start clears it and wins over a set.
   always_ff @(posedge clk) begin
      if (!reset) begin
         err_q <= 1'b0;
      end else if (accept) begin
         err_q <= 1'b0;
      end else if (err_set) begin
         err_q <= 1'b1;
      end
   end

   assign bus.err = err_q;
`endif

endmodule

// File: tb/tb_seq_step_sequencer.sv
// Directed testbench for seq_step_sequencer (CNT_W=4, MAX_STEPS=16).
// Status is compared as one packed vector {busy, done, count_check, count}.
// The err scenario is compiled in when SEQ_STEP_SEQUENCER_ERR_EN is defined.
module tb_seq_step_sequencer;

   localparam int CNT_W = 4;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   seq_step_sequencer_if #(.CNT_W(CNT_W)) bus ();

   seq_step_sequencer #(.CNT_W(CNT_W), .MAX_STEPS(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [CNT_W+2:0] obs();
      return {bus.busy, bus.done, bus.count_check, bus.count};
   endfunction

   function automatic logic [CNT_W+2:0] st(input logic b, input logic d,
                                           input logic c, input int cnt);
      return {b, d, c, CNT_W'(cnt)};
   endfunction

   // Advance one rising edge, then settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input int l, input logic a, input logic sh);
      bus.start     = s;
      bus.len       = (CNT_W + 1)'(l);
      bus.add_shift = a;
      bus.shift     = sh;
   endtask

   task automatic test_reset();
      logic [CNT_W+2:0] e;
      reset = 1'b0;
      drive(1, 3, 1, 0);
      tick();
      tick();
      e = st(0, 0, 0, 0); checks++;
      if (obs() !== e) begin errors++; $display("FAIL reset_hold: got %b want %b", obs(), e); end
      reset = 1'b1;
      drive(0, 0, 0, 0);
      tick();
      e = st(0, 0, 0, 0); checks++;
      if (obs() !== e) begin errors++; $display("FAIL reset_release_idle: got %b want %b", obs(), e); end
      drive(0, 0, 1, 1);
      tick();
      drive(0, 0, 0, 0);
      e = st(0, 0, 0, 0); checks++;
      if (obs() !== e) begin errors++; $display("FAIL idle_ignores_strobes: got %b want %b", obs(), e); end
   endtask

   task automatic test_default_len();
      logic [CNT_W+2:0] e;
      drive(1, 0, 0, 0);
      tick();
      drive(0, 0, 1, 0);
      for (int i = 0; i < 16; i++) begin
         e = st(1, 0, (i == 15), i); checks++;
         if (obs() !== e) begin errors++; $display("FAIL default_len_step%0d: got %b want %b", i, obs(), e); end
         tick();
      end
      drive(0, 0, 0, 0);
      e = st(0, 1, 0, 0); checks++;
      if (obs() !== e) begin errors++; $display("FAIL default_len_done: got %b want %b", obs(), e); end
      tick();
      e = st(0, 0, 0, 0); checks++;
      if (obs() !== e) begin errors++; $display("FAIL default_len_idle: got %b want %b", obs(), e); end
   endtask

   task automatic test_mixed_strobes();
      logic [CNT_W+2:0] e;
      logic [1:0] strobes [9] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b11, 2'b01, 2'b00, 2'b10};
      logic [CNT_W+2:0] want [9];
      want = '{st(1, 0, 0, 1), st(1, 0, 0, 1), st(1, 0, 0, 2), st(1, 0, 0, 2), st(1, 0, 0, 2),
               st(1, 0, 0, 3), st(1, 0, 1, 4), st(1, 0, 1, 4), st(0, 1, 0, 0)};
      drive(1, 5, 0, 0);
      tick();
      for (int i = 0; i < 9; i++) begin
         drive(0, 0, strobes[i][1], strobes[i][0]);
         tick();
         e = want[i]; checks++;
         if (obs() !== e) begin errors++; $display("FAIL mixed_cycle%0d: got %b want %b", i, obs(), e); end
      end
      drive(0, 0, 0, 0);
      tick();
      e = st(0, 0, 0, 0); checks++;
      if (obs() !== e) begin errors++; $display("FAIL mixed_idle: got %b want %b", obs(), e); end
   endtask

   task automatic test_back_to_back();
      logic [CNT_W+2:0] e;
      drive(1, 2, 0, 0);
      tick();
      drive(1, 3, 1, 0);
      tick();
      e = st(1, 0, 1, 1); checks++;
      if (obs() !== e) begin errors++; $display("FAIL start_in_run_no_restart: got %b want %b", obs(), e); end
      drive(0, 0, 1, 0);
      tick();
      e = st(0, 1, 0, 0); checks++;
      if (obs() !== e) begin errors++; $display("FAIL len2_done: got %b want %b", obs(), e); end
      drive(1, 20, 0, 0);
      tick();
      e = st(1, 0, 0, 0); checks++;
      if (obs() !== e) begin errors++; $display("FAIL b2b_restart: got %b want %b", obs(), e); end
      drive(0, 0, 0, 1);
      for (int i = 0; i < 15; i++) tick();
      e = st(1, 0, 1, 15); checks++;
      if (obs() !== e) begin errors++; $display("FAIL clamp_last_step: got %b want %b", obs(), e); end
      tick();
      drive(0, 0, 1, 0);
      e = st(0, 1, 0, 0); checks++;
      if (obs() !== e) begin errors++; $display("FAIL clamp_done: got %b want %b", obs(), e); end
      tick();
      drive(0, 0, 0, 0);
      e = st(0, 0, 0, 0); checks++;
      if (obs() !== e) begin errors++; $display("FAIL done_ignores_strobe: got %b want %b", obs(), e); end
      drive(1, 1, 0, 0);
      tick();
      e = st(1, 0, 1, 0); checks++;
      if (obs() !== e) begin errors++; $display("FAIL len1_run: got %b want %b", obs(), e); end
      drive(0, 0, 1, 0);
      tick();
      drive(0, 0, 0, 0);
      e = st(0, 1, 0, 0); checks++;
      if (obs() !== e) begin errors++; $display("FAIL len1_done: got %b want %b", obs(), e); end
      tick();
   endtask

   task automatic test_reset_mid_op();
      logic [CNT_W+2:0] e;
      drive(1, 8, 0, 0);
      tick();
      drive(0, 0, 1, 0);
      for (int i = 0; i < 3; i++) tick();
      drive(0, 0, 0, 0);
      e = st(1, 0, 0, 3); checks++;
      if (obs() !== e) begin errors++; $display("FAIL mid_before_reset: got %b want %b", obs(), e); end
      reset = 1'b0;
      tick();
      reset = 1'b1;
      e = st(0, 0, 0, 0); checks++;
      if (obs() !== e) begin errors++; $display("FAIL mid_reset: got %b want %b", obs(), e); end
      tick();
      e = st(0, 0, 0, 0); checks++;
      if (obs() !== e) begin errors++; $display("FAIL mid_no_done: got %b want %b", obs(), e); end
      drive(1, 8, 0, 0);
      tick();
      drive(0, 0, 0, 1);
      for (int i = 0; i < 7; i++) tick();
      e = st(1, 0, 1, 7); checks++;
      if (obs() !== e) begin errors++; $display("FAIL mid_rerun_last: got %b want %b", obs(), e); end
      tick();
      drive(0, 0, 0, 0);
      e = st(0, 1, 0, 0); checks++;
      if (obs() !== e) begin errors++; $display("FAIL mid_rerun_done: got %b want %b", obs(), e); end
      tick();
   endtask

`ifdef SEQ_STEP_SEQUENCER_ERR_EN
   task automatic test_err();
      logic [CNT_W+2:0] e;
      checks++;
      if (bus.err !== 1'b0) begin errors++; $display("FAIL err_initial: got %b want 0", bus.err); end
      drive(0, 0, 0, 1);
      tick();
      drive(0, 0, 0, 0);
      tick();
      checks++;
      if (bus.err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", bus.err); end
      drive(1, 3, 0, 0);
      tick();
      checks++;
      if (bus.err !== 1'b0) begin errors++; $display("FAIL err_clear_on_start: got %b want 0", bus.err); end
      drive(0, 0, 1, 0);
      tick();
      drive(1, 9, 0, 0);
      tick();
      e = st(1, 0, 0, 1); checks++;
      if (obs() !== e || bus.err !== 1'b1) begin
         errors++; $display("FAIL err_start_in_run: got %b/%b want %b/1", obs(), bus.err, e);
      end
      drive(0, 0, 1, 0);
      tick();
      tick();
      drive(1, 2, 0, 1);
      tick();
      drive(0, 0, 0, 0);
      e = st(1, 0, 0, 0); checks++;
      if (obs() !== e || bus.err !== 1'b0) begin
         errors++; $display("FAIL err_start_priority: got %b/%b want %b/0", obs(), bus.err, e);
      end
      drive(0, 0, 1, 0);
      tick();
      tick();
      drive(0, 0, 0, 0);
      tick();
   endtask
`endif

   initial begin
      reset = 1'b0;
      drive(0, 0, 0, 0);
      test_reset();
      test_default_len();
      test_mixed_strobes();
      test_back_to_back();
      test_reset_mid_op();
`ifdef SEQ_STEP_SEQUENCER_ERR_EN
      test_err();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_step_sequencer.md
Name: seq_step_sequencer

Overview:
- Parametrised step sequencer for the sequential multiplier datapath; next generation of the fixed 4-bit/16-step step counter.
- Counts add-shift/shift steps for a programmable operation length latched at start.
- Exposes a last-step flag, a busy level and a one-cycle done pulse to the multiplier controller.
- Sits between the controller FSM and the multiplier datapath.

Parameters:
- CNT_W, 4, width of the count output in bits.
- MAX_STEPS, 16, default and maximum steps per operation. Legal range 1..2^CNT_W; an illegal value is an elaboration error.

Ports:
- clk  input  1  Clock; all logic on rising edge.
- reset  input  1  Synchronous, active-low reset: reset==0 at a rising clk edge resets the block.
- start  input  1  Request a new operation; sampled per Behaviour.
- len  input  CNT_W+1  Step count for the operation; latched on an accepted start.
- add_shift  input  1  Step strobe: add-then-shift cycle.
- shift  input  1  Step strobe: shift-only cycle.
- count  output  CNT_W  Index of the current step, 0..len_q-1.
- count_check  output  1  High while busy and count==len_q-1 (current step is the last one).
- busy  output  1  Operation in progress (state RUN).
- done  output  1  Single-cycle pulse after the last step completes.

Behaviour:
- States: IDLE, RUN, DONE. Registered state.
- Reset (reset==0 at posedge), overriding all other inputs, including mid-operation:
  - state=IDLE, count=0, len_q=MAX_STEPS
  - busy=0, done=0, count_check=0
- step = add_shift | shift. Both strobes high in one cycle counts as one step.
- IDLE:
  - start=1 accepts: len_q <= (len==0 || len>MAX_STEPS) ? MAX_STEPS : len; count <= 0; next state RUN.
  - Step strobes are ignored.
- RUN:
  - busy=1.
  - On step with count==len_q-1: count <= 0, next state DONE.
  - On step with any other count: count <= count+1.
  - No step: hold.
  - start is ignored; len_q is never changed during RUN.
- DONE:
  - done=1 for exactly this one cycle; busy=0.
  - start=1 in this cycle is accepted exactly as in IDLE (back-to-back operations); next state RUN.
  - Otherwise next state IDLE.
  - Step strobes are ignored.
- Latency:
  - start accepted at edge t -> busy=1 from cycle t+1.
  - Last step accepted at edge t -> done=1 and busy=0 in cycle t+1.
  - A len_q=N operation therefore needs N step strobes.
- count_check is combinational from registered state, count and len_q (no input paths).
- count never exceeds len_q-1, so no modular wrap is required. With len_q=2^CNT_W, count runs 0..2^CNT_W-1, then returns to 0.
- len_q=1: the first step in RUN both sets count_check=1 and completes the operation.
- done and busy are never high together.

Optional Feature:
- Macro SEQ_STEP_SEQUENCER_ERR_EN.
- Defined:
  - Adds output port err (1 bit), reset to 0.
  - err is set (sticky) on any step strobe in IDLE or DONE, or on start=1 during RUN.
  - Cleared by reset or by an accepted start. An accepted start takes priority over a simultaneous set condition.
- Undefined:
  - No err port; those events are silently ignored as above.
  - Functional behaviour is otherwise identical.

Test Plan:
- Reset/defaults: hold reset=0 for 2 cycles, with start=1 and add_shift=1 driven during reset -> count=0, busy=0, done=0, count_check=0; the block is still IDLE after reset releases.
- Default length: start with len=0, then 16 add_shift pulses -> count steps 0..15, count_check=1 only at count=15, done=1 exactly one cycle after the 16th step, busy=0 in that cycle.
- Programmable length and mixed strobes: len=5, steps alternate add_shift/shift with idle gaps, plus one cycle with both high -> exactly 5 step events; done follows the 5th; count holds across gaps.
- Back-to-back and clamping: start held high in the DONE cycle with len=20 (MAX_STEPS=16) -> busy=1 the next cycle, len_q=16; start during RUN does not restart; len=1 operation completes on its first step.
- Reset mid-operation: len=8, after 3 steps drive reset=0 for one cycle -> count=0, busy=0, no done pulse; a subsequent start and 8 steps complete normally.
- With SEQ_STEP_SEQUENCER_ERR_EN: shift pulse in IDLE -> err=1 and stays high; the next accepted start clears err; start during RUN sets err, with count unaffected.
